// File: rtl/data_memory_ctrl.sv
// Single-port data memory with valid/ready requests, 1-cycle registered read,
// byte enables, range check and a sequential clear engine. Optional DMEM_PARITY_EN.
module data_memory_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_start,
    output logic                busy,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
    input  logic                perr_inj,
    output logic                rsp_perr,
`endif
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the response appears as a one-cycle rsp_valid pulse on the following cycle.
    localparam int NB = DATA_W / 8;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   mem_q [0:DEPTH-1];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NB-1:0]       mem_wbe;
    logic                accept;
    logic                in_range;
    logic [DATA_W-1:0]   rd_word;

    assign in_range  = (32'(req_addr) < 32'(DEPTH));
    assign req_ready = (state_q == IDLE) && !clr_start;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q == CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        mem_wbe   = req_be;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end else if (accept && req_we && in_range) begin
                    mem_we = 1'b1;
                end
            end
        endcase
    end

    // Out-of-range addresses never index storage, so no X leaks into the read path.
    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = mem_q[req_addr];
    end

    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && !in_range;
        rsp_rdata_d = '0;
        if (accept && !req_we && in_range) rsp_rdata_d = rd_word;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] par_q [0:DEPTH-1];
    logic          rsp_perr_q, rsp_perr_d;
    logic          inj_eff;

    // The clear engine never injects, so cleared words carry correct parity 0.
    assign inj_eff = perr_inj && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) par_q[mem_waddr][i] <= (^mem_wdata[8*i +: 8]) ^ inj_eff;
            end
        end
    end

    always_comb begin
        rsp_perr_d = 1'b0;
        if (accept && !req_we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                rsp_perr_d = rsp_perr_d | (par_q[req_addr][i] ^ (^rd_word[8*i +: 8]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsp_perr_q <= 1'b0;
        else      rsp_perr_q <= rsp_perr_d;
    end

    assign rsp_perr = rsp_perr_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (DATA_W=32, ADDR_W=8, DEPTH=200).
// Parity checks are included when DMEM_PARITY_EN is defined.
module tb_data_memory_ctrl;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DP = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_start;
    logic          busy;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_be;
    logic          perr_inj;
    logic          rsp_perr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [0:DP-1];

    data_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .busy      (busy),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
`ifdef DMEM_PARITY_EN
        .perr_inj  (perr_inj),
        .rsp_perr  (rsp_perr),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

`ifndef DMEM_PARITY_EN
    assign rsp_perr = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the response.
    task automatic step(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] be, input logic inj, input logic [DW-1:0] exp_rd,
                        input logic exp_err, input logic exp_perr, input string tag);
        logic [DW-1:0] e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        perr_inj  = inj;
        #1;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        exp_q.push_back(exp_rd);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rdata"}, rsp_rdata, e);
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
`ifdef DMEM_PARITY_EN
        if (!we) chk({tag, " perr"}, 32'(rsp_perr), 32'(exp_perr));
`else
        if (exp_perr) chk({tag, " perr"}, 32'(rsp_perr), 32'd1);
`endif
        if (we && 32'(addr) < DP) begin
            for (int i = 0; i < 4; i++) if (be[i]) model[addr][8*i +: 8] = wd[8*i +: 8];
        end
        req_valid = 1'b0;
        perr_inj  = 1'b0;
    endtask

    // Called at a falling edge right after reset release or clear start.
    task automatic clear_wait(input string tag);
        int cnt = 0;
        int ready_seen = 0;
        while (busy && cnt < 1000) begin
            if (req_ready) ready_seen++;
            cnt++;
            @(negedge clk);
        end
        chk({tag, " len"}, 32'(cnt), 32'(DP));
        chk({tag, " ready_low"}, 32'(ready_seen), 32'd0);
        for (int i = 0; i < DP; i++) model[i] = '0;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, " idle valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle rdata"}, rsp_rdata, 32'd0);
        chk({tag, " idle err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        rst = 1'b0; clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0; perr_inj = 1'b0;
        for (int i = 0; i < DP; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst valid", 32'(rsp_valid), 32'd0);
        chk("rst rdata", rsp_rdata, 32'd0);
        chk("rst err", 32'(rsp_err), 32'd0);
        chk("rst perr", 32'(rsp_perr), 32'd0);
        rst = 1'b1;
        clear_wait("init clear");

        // Cleared storage reads zero, including the last implemented word.
        step(1'b0, 8'hC7, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, "rd last");
        step(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, "rd first");
        idle_chk("t1");

        step(1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, "wr full");
        step(1'b1, 8'h10, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1'b0, 1'b0, "wr be5");
        step(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 32'hAA22CC44, 1'b0, 1'b0, "rd merge");
        step(1'b1, 8'h10, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, "wr be0");
        step(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 32'hAA22CC44, 1'b0, 1'b0, "rd be0");
        step(1'b1, 8'h11, 32'hDEADBEEF, 4'b1010, 1'b0, 32'h0, 1'b0, 1'b0, "wr be10");
        step(1'b0, 8'h11, 32'h0, 4'h0, 1'b0, 32'hDE00BE00, 1'b0, 1'b0, "rd be10");

        step(1'b1, 8'h03, 32'h5A, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, "wr 03");
        step(1'b0, 8'h03, 32'h0, 4'h0, 1'b0, 32'h5A, 1'b0, 1'b0, "rd 03 b2b");
        idle_chk("t3");

        step(1'b1, 8'hC7, 32'h76543210, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, "wr C7");
        step(1'b0, 8'hC8, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, "rd C8 err");
        step(1'b1, 8'hC8, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0, "wr C8 err");
        step(1'b0, 8'hFF, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, "rd FF err");
        for (int a = 0; a < DP; a++)
            step(1'b0, AW'(a), 32'h0, 4'h0, 1'b0, model[a], 1'b0, 1'b0, "sweep");
        idle_chk("t4");

`ifdef DMEM_PARITY_EN
        step(1'b1, 8'h05, 32'h0000000F, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, "wr inj");
        step(1'b0, 8'h05, 32'h0, 4'h0, 1'b0, 32'h0000000F, 1'b0, 1'b1, "rd perr");
        step(1'b1, 8'h05, 32'h0000000F, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, "wr noinj");
        step(1'b0, 8'h05, 32'h0, 4'h0, 1'b0, 32'h0000000F, 1'b0, 1'b0, "rd noperr");
`endif

        // clr_start wins over a same-cycle request.
        clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        #1;
        chk("clr ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("clr busy", 32'(busy), 32'd1);
        chk("clr no rsp", 32'(rsp_valid), 32'd0);
        clr_start = 1'b0; req_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid clr busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid rst busy", 32'(busy), 32'd1);
        chk("mid rst valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_wait("restart clear");
        step(1'b0, 8'h03, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, "rd 03 clr");
        step(1'b0, 8'h20, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, "rd 20 drop");
        step(1'b0, 8'hC7, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, "rd C7 clr");

        // Reset right after an accepting edge drops the pending response.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
        @(posedge clk);
        #1;
        chk("pend valid", 32'(rsp_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("pend dropped", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_wait("post rst clear");
        step(1'b1, 8'h07, 32'h01020304, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, "wr 07");
        step(1'b0, 8'h07, 32'h0, 4'h0, 1'b0, 32'h01020304, 1'b0, 1'b0, "rd 07");
        idle_chk("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
